// File: rtl/apb_cmd_pkg.sv
// Shared types and defaults for the APB command master.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
package apb_cmd_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT    = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/apb_wdog.sv
// ACCESS-phase wait counter; expire pulses on the LIMIT-th enabled cycle.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_wdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  assign expire = enable && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding command-to-APB initiator with registered APB outputs.
// Define APB_TIMEOUT_EN to bound the ACCESS-phase wait at TIMEOUT_CYCLES.
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  RSP_SLVERR,
  output logic                  RSP_TIMEOUT,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  state_e state_q, state_d;
  logic   ready_q;
  logic   hs;
  logic   apb_done;
  logic   expire;

  assign REQ_READY = ready_q;
  assign hs        = REQ_VALID & ready_q;
  assign apb_done  = PSEL & PENABLE & PREADY;

`ifdef APB_TIMEOUT_EN
  logic wd_en;
  logic wd_clr;

  assign wd_en  = (state_q == ST_ACCESS) & ~PREADY;
  assign wd_clr = (state_q == ST_SETUP);

  apb_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (CLK),
    .rst_n  (RESETN),
    .enable (wd_en),
    .clear  (wd_clr),
    .expire (expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire         = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (hs) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (apb_done || expire) state_d = ST_RESP;
      ST_RESP:   if (RSP_READY) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs follow the next state so they toggle with it, from flops only.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ready_q     <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      RSP_VALID   <= 1'b0;
      RSP_RDATA   <= '0;
      RSP_SLVERR  <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
    end else begin
      ready_q   <= (state_d == ST_IDLE);
      PSEL      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      PENABLE   <= (state_d == ST_ACCESS);
      RSP_VALID <= (state_d == ST_RESP);
      if (hs) begin
        PADDR  <= REQ_ADDR;
        PWRITE <= REQ_WRITE;
        PWDATA <= REQ_WRITE ? REQ_WDATA : '0;
      end
      if (state_q == ST_ACCESS) begin
        if (apb_done) begin
          RSP_RDATA   <= PWRITE ? '0 : PRDATA;
          RSP_SLVERR  <= PSLVERR;
          RSP_TIMEOUT <= 1'b0;
        end else if (expire) begin
          RSP_RDATA   <= '0;
          RSP_SLVERR  <= 1'b1;
          RSP_TIMEOUT <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed self-checking bench for apb_cmd_master.
// Timeout scenarios run only when APB_TIMEOUT_EN is defined.
module tb_apb_cmd_master;

  logic        CLK;
  logic        RESETN;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        RSP_SLVERR;
  logic        RSP_TIMEOUT;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_total = 0;
  int n_pass  = 0;

  apb_cmd_master #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .REQ_VALID   (REQ_VALID),
    .REQ_READY   (REQ_READY),
    .REQ_WRITE   (REQ_WRITE),
    .REQ_ADDR    (REQ_ADDR),
    .REQ_WDATA   (REQ_WDATA),
    .RSP_VALID   (RSP_VALID),
    .RSP_READY   (RSP_READY),
    .RSP_RDATA   (RSP_RDATA),
    .RSP_SLVERR  (RSP_SLVERR),
    .RSP_TIMEOUT (RSP_TIMEOUT),
    .PADDR       (PADDR),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESETN = 1'b0; REQ_VALID = 1'b1; REQ_WRITE = 1'b1;
    REQ_ADDR = 32'h44; REQ_WDATA = 32'h55;
    RSP_READY = 1'b0; PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
    tick();
    tick();
    n_total++;
    if ({PSEL, PENABLE, PWRITE, RSP_VALID, RSP_SLVERR, RSP_TIMEOUT, REQ_READY} !== 7'b0)
      $display("FAIL rst_ctrl got %b want 0", {PSEL, PENABLE, PWRITE, RSP_VALID, RSP_SLVERR, RSP_TIMEOUT, REQ_READY});
    else n_pass++;
    n_total++;
    if ({PADDR, PWDATA, RSP_RDATA} !== 96'h0)
      $display("FAIL rst_data got %h want 0", {PADDR, PWDATA, RSP_RDATA});
    else n_pass++;
    REQ_VALID = 1'b0;
    #2 RESETN = 1'b1;
    #1;
    n_total++;
    if (REQ_READY !== 1'b0) $display("FAIL rst_ready_early got %b want 0", REQ_READY);
    else n_pass++;
    tick();
    n_total++;
    if (REQ_READY !== 1'b1) $display("FAIL rst_ready_edge got %b want 1", REQ_READY);
    else n_pass++;
  endtask

  task automatic test_write_zero_wait();
    PREADY = 1'b1; PSLVERR = 1'b0;
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1;
    REQ_ADDR = 32'h0000_0010; REQ_WDATA = 32'hDEAD_BEEF;
    tick();
    REQ_VALID = 1'b0;
    n_total++;
    if ({PSEL, PENABLE, PWRITE, REQ_READY, RSP_VALID} !== 5'b10100)
      $display("FAIL wr_setup_ctrl got %b want 10100", {PSEL, PENABLE, PWRITE, REQ_READY, RSP_VALID});
    else n_pass++;
    n_total++;
    if (PADDR !== 32'h10 || PWDATA !== 32'hDEAD_BEEF)
      $display("FAIL wr_setup_bus got %h/%h want 10/deadbeef", PADDR, PWDATA);
    else n_pass++;
    tick();
    n_total++;
    if ({PSEL, PENABLE, RSP_VALID} !== 3'b110)
      $display("FAIL wr_access got %b want 110", {PSEL, PENABLE, RSP_VALID});
    else n_pass++;
    tick();
    n_total++;
    if ({PSEL, PENABLE, RSP_VALID, RSP_SLVERR, RSP_TIMEOUT} !== 5'b00100)
      $display("FAIL wr_resp_ctrl got %b want 00100", {PSEL, PENABLE, RSP_VALID, RSP_SLVERR, RSP_TIMEOUT});
    else n_pass++;
    n_total++;
    if (RSP_RDATA !== 32'h0) $display("FAIL wr_resp_rdata got %h want 0", RSP_RDATA);
    else n_pass++;
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    n_total++;
    if ({RSP_VALID, REQ_READY} !== 2'b01)
      $display("FAIL wr_idle got %b want 01", {RSP_VALID, REQ_READY});
    else n_pass++;
  endtask

  task automatic test_read_wait();
    PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'h1234_5678;
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0;
    REQ_ADDR = 32'h0000_0004; REQ_WDATA = 32'hFFFF_FFFF;
    tick();
    REQ_VALID = 1'b0;
    n_total++;
    if (PWRITE !== 1'b0 || PWDATA !== 32'h0 || PADDR !== 32'h4)
      $display("FAIL rd_setup got %b/%h/%h want 0/0/4", PWRITE, PWDATA, PADDR);
    else n_pass++;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if ({PSEL, PENABLE, RSP_VALID} !== 3'b110 || PADDR !== 32'h4)
        $display("FAIL rd_wait%0d got %b/%h want 110/4", i, {PSEL, PENABLE, RSP_VALID}, PADDR);
      else n_pass++;
      tick();
    end
    n_total++;
    if ({PSEL, PENABLE, RSP_VALID} !== 3'b110)
      $display("FAIL rd_access6 got %b want 110", {PSEL, PENABLE, RSP_VALID});
    else n_pass++;
    PREADY = 1'b1; PSLVERR = 1'b0;
    tick();
    PRDATA = 32'hBAD0_BAD0;
    n_total++;
    if ({RSP_VALID, RSP_SLVERR, RSP_TIMEOUT, PSEL} !== 4'b1000)
      $display("FAIL rd_resp_ctrl got %b want 1000", {RSP_VALID, RSP_SLVERR, RSP_TIMEOUT, PSEL});
    else n_pass++;
    n_total++;
    if (RSP_RDATA !== 32'h1234_5678) $display("FAIL rd_rdata got %h want 12345678", RSP_RDATA);
    else n_pass++;
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
  endtask

  task automatic test_slverr();
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hCAFE_F00D;
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1;
    REQ_ADDR = 32'h0000_0020; REQ_WDATA = 32'h0000_0001;
    tick();
    REQ_VALID = 1'b0;
    tick();
    tick();
    n_total++;
    if ({RSP_VALID, RSP_SLVERR, RSP_TIMEOUT} !== 3'b110)
      $display("FAIL err_resp got %b want 110", {RSP_VALID, RSP_SLVERR, RSP_TIMEOUT});
    else n_pass++;
    n_total++;
    if (RSP_RDATA !== 32'h0) $display("FAIL err_rdata got %h want 0", RSP_RDATA);
    else n_pass++;
    PSLVERR = 1'b0;
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
  endtask

  task automatic test_back_to_back();
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hA5A5_0001;
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0;
    REQ_ADDR = 32'h0000_0030; REQ_WDATA = '0;
    tick();
    tick();
    tick();
    PRDATA = 32'h0000_FFFF;
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if ({RSP_VALID, REQ_READY, PSEL} !== 3'b100 || RSP_RDATA !== 32'hA5A5_0001)
        $display("FAIL bp_hold%0d got %b/%h want 100/a5a50001", i, {RSP_VALID, REQ_READY, PSEL}, RSP_RDATA);
      else n_pass++;
      tick();
    end
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    n_total++;
    if ({RSP_VALID, REQ_READY, PSEL} !== 3'b010)
      $display("FAIL bp_idle got %b want 010", {RSP_VALID, REQ_READY, PSEL});
    else n_pass++;
    tick();
    REQ_VALID = 1'b0;
    n_total++;
    if ({PSEL, PENABLE, PADDR} !== {2'b10, 32'h30})
      $display("FAIL bp_retry got %b/%h want 10/30", {PSEL, PENABLE}, PADDR);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'h0000_FFFF)
      $display("FAIL bp_retry_resp got %b/%h want 1/0000ffff", RSP_VALID, RSP_RDATA);
    else n_pass++;
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
  endtask

  task automatic test_reset_mid();
    PREADY = 1'b0; PSLVERR = 1'b0;
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1;
    REQ_ADDR = 32'h0000_0040; REQ_WDATA = 32'h1111_2222;
    tick();
    REQ_VALID = 1'b0;
    tick();
    tick();
    #2 RESETN = 1'b0;
    #1;
    n_total++;
    if ({PSEL, PENABLE, RSP_VALID, REQ_READY} !== 4'b0000)
      $display("FAIL mid_rst got %b want 0000", {PSEL, PENABLE, RSP_VALID, REQ_READY});
    else n_pass++;
    PREADY = 1'b1;
    #2 RESETN = 1'b1;
    tick();
    n_total++;
    if ({REQ_READY, RSP_VALID, PSEL} !== 3'b100)
      $display("FAIL mid_after got %b want 100", {REQ_READY, RSP_VALID, PSEL});
    else n_pass++;
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1;
    REQ_ADDR = 32'h0000_0050; REQ_WDATA = 32'h3333_4444;
    tick();
    REQ_VALID = 1'b0;
    n_total++;
    if (PSEL !== 1'b1 || PWDATA !== 32'h3333_4444 || PADDR !== 32'h50)
      $display("FAIL mid_fresh_setup got %b/%h/%h want 1/33334444/50", PSEL, PWDATA, PADDR);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if ({RSP_VALID, RSP_SLVERR, RSP_TIMEOUT} !== 3'b100)
      $display("FAIL mid_fresh_resp got %b want 100", {RSP_VALID, RSP_SLVERR, RSP_TIMEOUT});
    else n_pass++;
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h7777_7777;
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0;
    REQ_ADDR = 32'h0000_0060; REQ_WDATA = '0;
    tick();
    REQ_VALID = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if ({PSEL, PENABLE} !== 2'b11)
        $display("FAIL to_access%0d got %b want 11", i, {PSEL, PENABLE});
      else n_pass++;
      tick();
    end
    n_total++;
    if ({PSEL, PENABLE, RSP_VALID, RSP_SLVERR, RSP_TIMEOUT} !== 5'b00111 || RSP_RDATA !== 32'h0)
      $display("FAIL to_resp got %b/%h want 00111/0",
               {PSEL, PENABLE, RSP_VALID, RSP_SLVERR, RSP_TIMEOUT}, RSP_RDATA);
    else n_pass++;
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    REQ_VALID = 1'b1;
    tick();
    REQ_VALID = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    PREADY = 1'b1;
    tick();
    n_total++;
    if ({RSP_VALID, RSP_SLVERR, RSP_TIMEOUT} !== 3'b100 || RSP_RDATA !== 32'h7777_7777)
      $display("FAIL to_limit_ok got %b/%h want 100/77777777",
               {RSP_VALID, RSP_SLVERR, RSP_TIMEOUT}, RSP_RDATA);
    else n_pass++;
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 Parameter DATA_WIDTH, default 32, APB read/write data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, ACCESS-phase wait limit (used only with APB_TIMEOUT_EN).
REQ-004 CLK  in  1  sole clock, all logic rising-edge.
REQ-005 RESETN  in  1  asynchronous active-low reset.
REQ-006 REQ_VALID  in  1  command present; REQ_READY  out  1  command accepted.
REQ-007 REQ_WRITE  in  1, REQ_ADDR  in  ADDR_WIDTH, REQ_WDATA  in  DATA_WIDTH  command fields.
REQ-008 RSP_VALID  out  1  response present; RSP_READY  in  1  response consumed.
REQ-009 RSP_RDATA  out  DATA_WIDTH, RSP_SLVERR  out  1, RSP_TIMEOUT  out  1  response fields.
REQ-010 PADDR  out  ADDR_WIDTH, PSEL  out  1, PENABLE  out  1, PWRITE  out  1, PWDATA  out  DATA_WIDTH  APB initiator outputs.
REQ-011 PRDATA  in  DATA_WIDTH, PREADY  in  1, PSLVERR  in  1  APB responder inputs.

Function
REQ-012 FSM states IDLE, SETUP, ACCESS, RESP; exactly one transfer outstanding.
REQ-013 REQ_READY SHALL be 1 only in IDLE; handshake = REQ_VALID & REQ_READY.
REQ-014 On handshake, command fields registered; next cycle SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = registered values.
REQ-015 SETUP -> ACCESS unconditionally after one cycle; ACCESS: PSEL=1, PENABLE=1, PADDR/PWRITE/PWDATA held stable.
REQ-016 ACCESS held while PREADY=0; on PREADY=1 capture PRDATA (reads; 0 for writes) and PSLVERR, go RESP.
REQ-017 In RESP: PSEL=0, PENABLE=0, RSP_VALID=1, RSP_* stable until RSP_READY=1; then IDLE next cycle.
REQ-018 Zero-wait responder latency: handshake cycle N, SETUP N+1, ACCESS N+2, RSP_VALID N+3.
REQ-019 REQ_VALID during SETUP/ACCESS/RESP ignored (REQ_READY=0); command not lost, retried by source.
REQ-020 PSLVERR sampled only when PSEL&PENABLE&PREADY; ignored otherwise.
REQ-021 PWDATA driven 0 and not updated on read commands.

Reset
REQ-022 RESETN low: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, RSP_VALID=0, RSP_RDATA=0, RSP_SLVERR=0, RSP_TIMEOUT=0, REQ_READY=0 while asserted.
REQ-023 Reset mid-transfer aborts immediately (asynchronous); no response generated for aborted command.
REQ-024 REQ_READY SHALL rise no earlier than first CLK edge after RESETN deassertion.

Configuration
REQ-025 Macro APB_TIMEOUT_EN defined: ACCESS wait counter counts cycles with PREADY=0; at TIMEOUT_CYCLES, PSEL/PENABLE drop, RESP entered with RSP_SLVERR=1, RSP_TIMEOUT=1, RSP_RDATA=0.
REQ-026 Counter cleared on entry to ACCESS; PREADY=1 on the limit cycle completes normally (no timeout).
REQ-027 Macro undefined: no counter, ACCESS waits indefinitely, RSP_TIMEOUT tied 0; port list identical.

Structure
REQ-028 Package apb_cmd_pkg holds state enum type and default width/timeout constants.
REQ-029 Timeout counter SHALL be sub-module apb_wdog (enable, clear, expire), instantiated only under APB_TIMEOUT_EN.
REQ-030 Implementation SHALL be a single registered FSM; all APB outputs register-driven, no combinational input-to-APB-output path.

Verification
REQ-031 Write 0x0000_0010 <- 0xDEAD_BEEF, PREADY always 1 -> PSEL rises N+1, PENABLE N+2, RSP_VALID N+3, SLVERR=0.
REQ-032 Read 0x0000_0004, PREADY low 5 cycles, PRDATA=0x1234_5678 -> ACCESS held 6 cycles, PADDR stable, RSP_RDATA=0x1234_5678.
REQ-033 Write with PSLVERR=1 at PREADY -> RSP_SLVERR=1, RSP_TIMEOUT=0.
REQ-034 RSP_READY held 0 for 10 cycles with REQ_VALID=1 -> RSP fields stable, REQ_READY=0, no second PSEL.
REQ-035 APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY stuck 0 -> PSEL drops after 16 ACCESS cycles, RSP_SLVERR=1, RSP_TIMEOUT=1.
REQ-036 RESETN low during ACCESS -> PSEL/PENABLE/RSP_VALID 0 same cycle; after release, fresh write completes normally.
